// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, fetches words over req/gnt/rvalid and queues two {pc, ins} for decode.
// Latency: IMEM_RVALID in cycle N shows as INS_VALID in N+1; at most one fetch in flight.
// Backpressure: INS_READY low fills the 2-entry queue, after which IMEM_REQ stays low until decode pops.

module fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat,
  output logic [CW-1:0]    count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop_fire;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_vld  = (count != '0);
  assign pop_fire = pop_vld & pop_rdy;
  assign pop_dat  = mem[rd_ptr];

  // Storage needs no reset: pop_vld masks whatever the entries hold.
  always_ff @(posedge clk) begin
    if (push_vld) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop_fire) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push_vld, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        INS_VALID,
  output logic [31:0] INS,
  output logic [31:0] PC,
  input  logic        INS_READY
);
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } fetch_ent_t;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]  state;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic        outstanding;
  logic [1:0]  fifo_count;
  logic [2:0]  occupancy;
  logic        grant;
  logic        push_vld;
  fetch_ent_t  push_dat;
  logic        head_vld;
  fetch_ent_t  head_dat;
  logic [31:0] redirect_tgt;
  logic        redirect_pc_unused;

  assign redirect_tgt       = {REDIRECT_PC[31:2], 2'b00};
  assign redirect_pc_unused = ^REDIRECT_PC[1:0];

  // Queue slots plus the in-flight fetch never exceed two, so a push always has room.
  assign occupancy = {1'b0, fifo_count} + {2'b00, outstanding};
  assign IMEM_REQ  = (state == REQ) && (occupancy < 3'd2);
  assign IMEM_ADDR = fetch_pc;
  assign grant     = IMEM_REQ & IMEM_GNT;

  // A response arriving with a redirect belongs to the old path and is dropped.
  assign push_vld = (state == WAIT) & IMEM_RVALID & ~REDIRECT;
  assign push_dat = {req_pc, IMEM_RDATA};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      req_pc      <= '0;
      outstanding <= 1'b0;
    end else begin
      if (grant) begin
        req_pc <= fetch_pc;
      end

      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (grant) begin
            outstanding <= 1'b1;
            state       <= REDIRECT ? DRAIN : WAIT;
          end
        end
        WAIT: begin
          if (IMEM_RVALID) begin
            outstanding <= 1'b0;
            state       <= REQ;
          end else if (REDIRECT) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (IMEM_RVALID) begin
            outstanding <= 1'b0;
            state       <= REQ;
          end
        end
        default: state <= IDLE;
      endcase

      if (REDIRECT) begin
        fetch_pc <= redirect_tgt;
      end else if (grant) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
    end
  end

  fifo #(
    .WIDTH($bits(fetch_ent_t)),
    .DEPTH(2)
  ) u_queue (
    .clk      (CLK),
    .rst_n    (RST_N),
    .flush    (REDIRECT),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_vld  (head_vld),
    .pop_rdy  (INS_READY),
    .pop_dat  (head_dat),
    .count    (fifo_count)
  );

  // Empty queue presents all-zero words so decode sees a bubble.
  assign INS_VALID = head_vld;
  assign INS       = head_vld ? head_dat.ins : '0;
  assign PC        = head_vld ? head_dat.pc  : '0;
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: memory model, PC model and {pc, ins} scoreboard driven cycle by cycle.
module tb_instruction_fetch;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT;
  logic        IMEM_RVALID;
  logic [31:0] IMEM_RDATA;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        INS_VALID;
  logic [31:0] INS;
  logic [31:0] PC;
  logic        INS_READY;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_gnt;
  logic        w_rvalid;
  logic [31:0] w_rdata;
  logic        w_ins_valid;
  logic [31:0] w_ins;
  logic [31:0] w_pc;

  always #5 CLK = ~CLK;

  instruction_fetch u_dut (
    .CLK(CLK), .RST_N(RST_N), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_GNT(IMEM_GNT),
    .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .INS_VALID(INS_VALID), .INS(INS), .PC(PC), .INS_READY(INS_READY)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .CLK(CLK), .RST_N(RST_N), .IMEM_REQ(w_req), .IMEM_ADDR(w_addr), .IMEM_GNT(w_gnt),
    .IMEM_RVALID(w_rvalid), .IMEM_RDATA(w_rdata), .REDIRECT(1'b0), .REDIRECT_PC(32'h0),
    .INS_VALID(w_ins_valid), .INS(w_ins), .PC(w_pc), .INS_READY(1'b1)
  );

  int checks;
  int errors;
  int cyc;
  logic cfg_gnt;
  int cfg_lat;
  logic mem_pend;
  logic [31:0] mem_addr;
  int mem_due;
  logic [31:0] tag_pc;
  int tag_epoch;
  logic [31:0] rsp_pc;
  int rsp_epoch;
  logic [31:0] exp_pc;
  int epoch;
  logic [63:0] sb[$];
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  logic [31:0] gnt_obs[$];
  logic [31:0] gnt_exp[$];
  int gnt_cyc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0013_0000;
  endfunction

  task automatic model_clear();
    cyc = 0; mem_pend = 1'b0; epoch = 0; rsp_epoch = -1; tag_epoch = -1;
    exp_pc = 32'h0;
    sb.delete(); exp_q.delete(); obs_q.delete();
    gnt_obs.delete(); gnt_exp.delete(); gnt_cyc.delete();
  endtask

  // Evaluate the current cycle in the models, cross the edge, then drive memory for the next cycle.
  task automatic tick();
    if (RST_N) begin
      if (INS_VALID && INS_READY) begin
        obs_q.push_back({PC, INS});
        if (sb.size() > 0) exp_q.push_back(sb.pop_front());
        else exp_q.push_back(64'hDEAD_BEEF_DEAD_BEEF);
      end
      if (IMEM_RVALID && !REDIRECT && rsp_epoch == epoch)
        sb.push_back({rsp_pc, mem_word(rsp_pc)});
      if (IMEM_REQ && IMEM_GNT) begin
        mem_pend = 1'b1; mem_addr = IMEM_ADDR; mem_due = cyc + cfg_lat;
        tag_pc = exp_pc; tag_epoch = epoch;
        gnt_obs.push_back(IMEM_ADDR); gnt_exp.push_back(exp_pc); gnt_cyc.push_back(cyc);
        exp_pc = exp_pc + 32'd4;
      end
      if (REDIRECT) begin
        exp_pc = {REDIRECT_PC[31:2], 2'b00};
        sb.delete();
        epoch++;
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
    REDIRECT = 1'b0;
    IMEM_GNT = cfg_gnt;
    IMEM_RVALID = 1'b0;
    IMEM_RDATA = 32'h0;
    if (mem_pend && cyc == mem_due) begin
      IMEM_RVALID = 1'b1; IMEM_RDATA = mem_word(mem_addr);
      rsp_pc = tag_pc; rsp_epoch = tag_epoch; mem_pend = 1'b0;
    end
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    REDIRECT = 1'b0; REDIRECT_PC = 32'h0; INS_READY = 1'b0;
    cfg_gnt = 1'b1; cfg_lat = 1;
    IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; IMEM_RDATA = 32'h0;
    w_gnt = 1'b1; w_rvalid = 1'b0; w_rdata = 32'h0;
    model_clear();
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    REDIRECT = 1'b0; REDIRECT_PC = 32'h0; INS_READY = 1'b0;
    IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; IMEM_RDATA = 32'h0;
    w_gnt = 1'b1; w_rvalid = 1'b0; w_rdata = 32'h0;
    #1 RST_N = 1'b0;
    #1;
    checks++; if (IMEM_REQ !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", IMEM_REQ); end
    checks++; if (IMEM_ADDR !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", IMEM_ADDR); end
    checks++; if (INS_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", INS_VALID); end
    checks++; if (INS !== 32'h0 || PC !== 32'h0) begin errors++; $display("FAIL reset_ins_pc: got %h/%h want 0/0", INS, PC); end
    checks++; if (w_addr !== 32'hFFFF_FFFC || w_req !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %h/%b want fffffffc/0", w_addr, w_req); end
  endtask

  task automatic test_stream();
    int first_valid;
    apply_reset();
    INS_READY = 1'b1;
    checks++; if (IMEM_REQ !== 1'b0) begin errors++; $display("FAIL stream_idle_req: got %b want 0", IMEM_REQ); end
    first_valid = -1;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (first_valid < 0 && INS_VALID === 1'b1) first_valid = t;
    end
    checks++; if (first_valid != 3) begin errors++; $display("FAIL stream_first_valid: got cycle %0d want 3", first_valid); end
    checks++; if (gnt_obs.size() != 7) begin errors++; $display("FAIL stream_grants: got %0d want 7", gnt_obs.size()); end
    for (int i = 0; i < gnt_obs.size(); i++) begin
      checks++;
      if (gnt_obs[i] !== 32'(4 * i) || gnt_exp[i] !== 32'(4 * i)) begin
        errors++; $display("FAIL stream_addr[%0d]: got %h want %h", i, gnt_obs[i], 32'(4 * i));
      end
    end
    for (int i = 1; i < gnt_cyc.size(); i++) begin
      checks++; if (gnt_cyc[i] - gnt_cyc[i-1] != 2) begin errors++; $display("FAIL stream_spacing[%0d]: got %0d want 2", i, gnt_cyc[i] - gnt_cyc[i-1]); end
    end
    checks++; if (obs_q.size() != 6) begin errors++; $display("FAIL stream_words: got %0d want 6", obs_q.size()); end
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || obs_q[i][63:32] !== 32'(4 * i)) begin
        errors++; $display("FAIL stream_word[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    repeat (8) tick();
    checks++; if (gnt_obs.size() != 2) begin errors++; $display("FAIL bp_grants: got %0d want 2", gnt_obs.size()); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (IMEM_REQ !== 1'b0 || INS_VALID !== 1'b1 || PC !== 32'h0 || INS !== mem_word(32'h0)) begin
        errors++; $display("FAIL bp_hold[%0d]: got req %b vld %b pc %h ins %h want 0 1 0 %h", k, IMEM_REQ, INS_VALID, PC, INS, mem_word(32'h0));
      end
      tick();
    end
    INS_READY = 1'b1;
    repeat (8) tick();
    checks++; if (gnt_obs.size() < 3 || gnt_obs[2] !== 32'h8) begin errors++; $display("FAIL bp_resume: got %0d grants, third %h want 8", gnt_obs.size(), (gnt_obs.size() > 2) ? gnt_obs[2] : 32'hX); end
    checks++; if (obs_q.size() < 3) begin errors++; $display("FAIL bp_words: got %0d want >=3", obs_q.size()); end
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || obs_q[i][63:32] !== 32'(4 * i)) begin
        errors++; $display("FAIL bp_word[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_redirect_rvalid();
    apply_reset();
    INS_READY = 1'b1;
    repeat (4) tick();
    REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_0103;
    tick();
    checks++; if (INS_VALID !== 1'b0) begin errors++; $display("FAIL rr_valid: got %b want 0", INS_VALID); end
    checks++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h100) begin errors++; $display("FAIL rr_addr: got %b/%h want 1/100", IMEM_REQ, IMEM_ADDR); end
    repeat (6) tick();
    checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL rr_words: got %0d want 3", obs_q.size()); end
    for (int i = 0; i < obs_q.size(); i++) begin
      logic [31:0] want_pc;
      want_pc = (i == 0) ? 32'h0 : 32'h100 + 32'(4 * (i - 1));
      checks++;
      if (obs_q[i] !== exp_q[i] || obs_q[i][63:32] !== want_pc) begin
        errors++; $display("FAIL rr_word[%0d]: got %h want pc %h (%h)", i, obs_q[i], want_pc, exp_q[i]);
      end
    end
  endtask

  task automatic test_redirect_wait();
    apply_reset();
    INS_READY = 1'b1; cfg_lat = 3;
    repeat (2) tick();
    REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_0200;
    tick();
    checks++; if (IMEM_REQ !== 1'b0 || INS_VALID !== 1'b0) begin errors++; $display("FAIL rw_drain1: got req %b vld %b want 0 0", IMEM_REQ, INS_VALID); end
    tick();
    checks++; if (IMEM_REQ !== 1'b0) begin errors++; $display("FAIL rw_drain2: got req %b want 0", IMEM_REQ); end
    tick();
    checks++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h200) begin errors++; $display("FAIL rw_addr: got %b/%h want 1/200", IMEM_REQ, IMEM_ADDR); end
    repeat (10) tick();
    checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL rw_words: got %0d want 2", obs_q.size()); end
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || obs_q[i][63:32] !== 32'h200 + 32'(4 * i)) begin
        errors++; $display("FAIL rw_word[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_redirect_nogrant();
    apply_reset();
    INS_READY = 1'b1; cfg_gnt = 1'b0;
    repeat (2) tick();
    checks++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h0) begin errors++; $display("FAIL rn_hold: got %b/%h want 1/0", IMEM_REQ, IMEM_ADDR); end
    REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_0400;
    tick();
    checks++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h400) begin errors++; $display("FAIL rn_addr: got %b/%h want 1/400", IMEM_REQ, IMEM_ADDR); end
    cfg_gnt = 1'b1; IMEM_GNT = 1'b1;
    tick();
    cfg_gnt = 1'b0; IMEM_GNT = 1'b0;
    repeat (5) tick();
    checks++; if (gnt_obs.size() != 1 || gnt_obs[0] !== 32'h400) begin errors++; $display("FAIL rn_grants: got %0d grants want 1 at 400", gnt_obs.size()); end
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0] || obs_q[0][63:32] !== 32'h400) begin
      errors++; $display("FAIL rn_word: got %0d words want 1 with pc 400", obs_q.size());
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    checks++; if (w_req !== 1'b0 || w_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_idle: got %b/%h want 0/fffffffc", w_req, w_addr); end
    tick();
    checks++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first: got %b/%h want 1/fffffffc", w_req, w_addr); end
    tick();
    checks++; if (w_req !== 1'b0 || w_addr !== 32'h0) begin errors++; $display("FAIL wrap_second_addr: got %b/%h want 0/0", w_req, w_addr); end
    w_rvalid = 1'b1; w_rdata = 32'h1234_5678;
    tick();
    w_rvalid = 1'b0; w_rdata = 32'h0;
    checks++;
    if (w_ins_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC || w_ins !== 32'h1234_5678 || w_req !== 1'b1 || w_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_word: got vld %b pc %h ins %h req %b addr %h want 1 fffffffc 12345678 1 0", w_ins_valid, w_pc, w_ins, w_req, w_addr);
    end
  endtask

  task automatic test_reset_midwait();
    apply_reset();
    cfg_lat = 3;
    repeat (6) tick();
    checks++; if (INS_VALID !== 1'b1 || IMEM_REQ !== 1'b0) begin errors++; $display("FAIL rm_pre: got vld %b req %b want 1 0", INS_VALID, IMEM_REQ); end
    RST_N = 1'b0;
    #1;
    checks++;
    if (IMEM_REQ !== 1'b0 || IMEM_ADDR !== 32'h0 || INS_VALID !== 1'b0 || INS !== 32'h0 || PC !== 32'h0) begin
      errors++; $display("FAIL rm_async: got req %b addr %h vld %b ins %h pc %h want all 0", IMEM_REQ, IMEM_ADDR, INS_VALID, INS, PC);
    end
    model_clear();
    IMEM_RVALID = 1'b0; cfg_lat = 1; INS_READY = 1'b1;
    repeat (2) @(negedge CLK);
    checks++; if (IMEM_REQ !== 1'b0) begin errors++; $display("FAIL rm_held: got req %b want 0", IMEM_REQ); end
    RST_N = 1'b1;
    tick();
    checks++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h0) begin errors++; $display("FAIL rm_restart: got %b/%h want 1/0", IMEM_REQ, IMEM_ADDR); end
    repeat (5) tick();
    checks++;
    if (obs_q.size() < 2 || obs_q[0] !== exp_q[0] || obs_q[0][63:32] !== 32'h0 || obs_q[1] !== exp_q[1]) begin
      errors++; $display("FAIL rm_words: got %0d words, first %h want pc 0 (%h)", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 64'hX, (exp_q.size() > 0) ? exp_q[0] : 64'hX);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    cfg_gnt = 1'b1; cfg_lat = 1;
    model_clear();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_rvalid();
    test_redirect_wait();
    test_redirect_nogrant();
    test_wrap();
    test_reset_midwait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
